// File: rtl/security_monitor.sv
// Defender-side alert FSM: escalates CALM -> WATCH -> ALARM on sustained attacker
// activity, cools down through COOLDOWN, and latches BREACHED when expansion is seen.
module security_monitor #(
    parameter int SUSPECT_TIME = 10,
    parameter int ALERT_TIME   = 8,
    parameter int RED_HOLD     = 15,
    parameter int COOL_TIME    = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    input  logic       deception_out,
    output logic       green,
    output logic       yellow,
    output logic       red,
    output logic       breach,
    output logic [2:0] current_state,
    output logic [5:0] timer,
    output logic [3:0] alarm_count
);

    typedef enum logic [2:0] {
        CALM     = 3'b000,
        WATCH    = 3'b001,
        ALARM    = 3'b010,
        COOLDOWN = 3'b011,
        BREACHED = 3'b100
    } state_e;

    localparam logic [5:0] SUSPECT_T = 6'(SUSPECT_TIME);
    localparam logic [5:0] ALERT_T   = 6'(ALERT_TIME);
    localparam logic [5:0] HOLD_T    = 6'(RED_HOLD);
    localparam logic [5:0] COOL_T    = 6'(COOL_TIME);

    state_e     state_q, state_d;
    logic [5:0] timer_q, timer_d;
    logic [3:0] alarm_count_q, alarm_count_d;
    logic       green_q, green_d;
    logic       yellow_q, yellow_d;
    logic       red_q, red_d;
    logic       breach_q, breach_d;

    logic       act_s;
    logic [5:0] timer_inc_s;
    logic [5:0] timer_hold_s;

    // Next-state, timer, counter and light decode for the alert FSM.
    always_comb begin
        act_s        = (a1 | a2) & ~deception_out;
        timer_inc_s  = (timer_q == 6'd63) ? 6'd63 : (timer_q + 6'd1);
        state_d      = state_q;
        timer_hold_s = timer_inc_s;

        case (state_q)
            CALM: begin
                if (a3) begin
                    state_d = BREACHED;
                end else if (a2 & ~deception_out) begin
                    state_d = ALARM;
                end else if (act_s) begin
                    state_d = (timer_q >= SUSPECT_T) ? WATCH : CALM;
                end else begin
                    // A single quiet cycle breaks the suspicion streak.
                    timer_hold_s = 6'd1;
                end
            end
            WATCH: begin
                if (a3) begin
                    state_d = BREACHED;
                end else if (act_s) begin
                    state_d = (timer_q >= ALERT_T) ? ALARM : WATCH;
                end else begin
                    state_d = COOLDOWN;
                end
            end
            ALARM: begin
                if (a3) begin
                    state_d = BREACHED;
                end else if ((timer_q >= HOLD_T) && !act_s) begin
                    state_d = COOLDOWN;
                end else begin
                    state_d = ALARM;
                end
            end
            COOLDOWN: begin
                if (a3) begin
                    state_d = BREACHED;
                end else if (act_s) begin
                    state_d = WATCH;
                end else begin
                    state_d = (timer_q >= COOL_T) ? CALM : COOLDOWN;
                end
            end
            BREACHED: begin
                state_d = BREACHED;
            end
            default: begin
                state_d = CALM;
            end
        endcase

        timer_d = (state_d != state_q) ? 6'd1 : timer_hold_s;

        alarm_count_d = ((state_d == ALARM) && (state_q != ALARM) && (alarm_count_q != 4'd15))
                        ? (alarm_count_q + 4'd1) : alarm_count_q;

        green_d  = (state_d == CALM);
        yellow_d = (state_d == WATCH) || (state_d == COOLDOWN);
        red_d    = (state_d == ALARM) || (state_d == BREACHED);
        breach_d = (state_d == BREACHED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= CALM;
            timer_q       <= 6'd1;
            alarm_count_q <= 4'd0;
            green_q       <= 1'b1;
            yellow_q      <= 1'b0;
            red_q         <= 1'b0;
            breach_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            alarm_count_q <= alarm_count_d;
            green_q       <= green_d;
            yellow_q      <= yellow_d;
            red_q         <= red_d;
            breach_q      <= breach_d;
        end
    end

    assign green         = green_q;
    assign yellow        = yellow_q;
    assign red           = red_q;
    assign breach        = breach_q;
    assign current_state = state_q;
    assign timer         = timer_q;
    assign alarm_count   = alarm_count_q;

endmodule

// File: tb/tb_security_monitor.sv
// Table-driven bench for security_monitor: each row repeats one input pattern N edges
// and then checks state, lights, breach, timer and alarm_count against hand values.
module tb_security_monitor;

    logic       clock = 1'b0;
    logic       reset, a1, a2, a3, deception_out;
    logic       green, yellow, red, breach;
    logic [2:0] current_state;
    logic [5:0] timer;
    logic [3:0] alarm_count;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    security_monitor dut (
        .clock        (clock),
        .reset        (reset),
        .a1           (a1),
        .a2           (a2),
        .a3           (a3),
        .deception_out(deception_out),
        .green        (green),
        .yellow       (yellow),
        .red          (red),
        .breach       (breach),
        .current_state(current_state),
        .timer        (timer),
        .alarm_count  (alarm_count)
    );

    always #5 clock = ~clock;

    // input codes {reset, a1, a2, a3, deception_out}
    localparam logic [4:0] Q    = 5'b00000;
    localparam logic [4:0] R    = 5'b10000;
    localparam logic [4:0] RA2  = 5'b10100;
    localparam logic [4:0] A1   = 5'b01000;
    localparam logic [4:0] A2   = 5'b00100;
    localparam logic [4:0] A3   = 5'b00010;
    localparam logic [4:0] A3A2 = 5'b00110;
    localparam logic [4:0] DA1  = 5'b01001;
    localparam logic [4:0] DA2  = 5'b00101;
    // light codes {green, yellow, red}
    localparam logic [2:0] G  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] RD = 3'b001;

    typedef struct {
        int         n;
        logic [4:0] in;
        logic [2:0] st;
        logic [2:0] gyr;
        logic       br;
        logic [5:0] tm;
        logic [3:0] ac;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic [4:0] in, input logic [2:0] st,
                       input logic [2:0] gyr, input logic br, input logic [5:0] tm,
                       input logic [3:0] ac);
        vec_t v;
        v.n = n; v.in = in; v.st = st; v.gyr = gyr; v.br = br; v.tm = tm; v.ac = ac;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [4:0] in);
        {reset, a1, a2, a3, deception_out} = in;
    endtask

    task automatic step(input logic [4:0] in, input int n);
        for (int k = 0; k < n; k++) begin
            drive(in);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Exactly one light on in every cycle once reset has been applied.
    always @(negedge clock) begin
        if (chk_en) begin
            nvec++;
            if ((int'(green) + int'(yellow) + int'(red)) != 1) begin
                nerr++;
                $display("FAIL onehot t=%0t: got g=%b y=%b r=%b, want exactly one", $time,
                         green, yellow, red);
            end
        end
    end

    initial begin
        add(1,  R,    3'd0, G,  1'b0, 6'd1,  4'd0);
        add(9,  A1,   3'd0, G,  1'b0, 6'd10, 4'd0);
        add(1,  A1,   3'd1, Y,  1'b0, 6'd1,  4'd0);
        add(7,  A2,   3'd1, Y,  1'b0, 6'd8,  4'd0);
        add(1,  A2,   3'd2, RD, 1'b0, 6'd1,  4'd1);
        add(14, DA1,  3'd2, RD, 1'b0, 6'd15, 4'd1);
        add(1,  DA1,  3'd3, Y,  1'b0, 6'd1,  4'd1);
        add(19, Q,    3'd3, Y,  1'b0, 6'd20, 4'd1);
        add(1,  Q,    3'd0, G,  1'b0, 6'd1,  4'd1);
        add(1,  A2,   3'd2, RD, 1'b0, 6'd1,  4'd2);
        add(70, A1,   3'd2, RD, 1'b0, 6'd63, 4'd2);
        add(1,  Q,    3'd3, Y,  1'b0, 6'd1,  4'd2);
        add(4,  Q,    3'd3, Y,  1'b0, 6'd5,  4'd2);
        add(1,  A1,   3'd1, Y,  1'b0, 6'd1,  4'd2);
        add(1,  A3,   3'd4, RD, 1'b1, 6'd1,  4'd2);
        add(5,  Q,    3'd4, RD, 1'b1, 6'd6,  4'd2);
        add(1,  R,    3'd0, G,  1'b0, 6'd1,  4'd0);
        add(1,  A3,   3'd4, RD, 1'b1, 6'd1,  4'd0);
        add(1,  R,    3'd0, G,  1'b0, 6'd1,  4'd0);
        add(1,  A2,   3'd2, RD, 1'b0, 6'd1,  4'd1);
        add(1,  A3,   3'd4, RD, 1'b1, 6'd1,  4'd1);
        add(1,  R,    3'd0, G,  1'b0, 6'd1,  4'd0);
        add(1,  A2,   3'd2, RD, 1'b0, 6'd1,  4'd1);
        add(15, DA1,  3'd3, Y,  1'b0, 6'd1,  4'd1);
        add(1,  A3,   3'd4, RD, 1'b1, 6'd1,  4'd1);
        add(1,  R,    3'd0, G,  1'b0, 6'd1,  4'd0);
        add(10, A1,   3'd1, Y,  1'b0, 6'd1,  4'd0);
        add(7,  A1,   3'd1, Y,  1'b0, 6'd8,  4'd0);
        add(1,  A3A2, 3'd4, RD, 1'b1, 6'd1,  4'd0);
        add(1,  R,    3'd0, G,  1'b0, 6'd1,  4'd0);
        add(1,  A2,   3'd2, RD, 1'b0, 6'd1,  4'd1);
        add(3,  A1,   3'd2, RD, 1'b0, 6'd4,  4'd1);
        add(1,  RA2,  3'd0, G,  1'b0, 6'd1,  4'd0);
        add(5,  DA1,  3'd0, G,  1'b0, 6'd1,  4'd0);
        add(1,  DA2,  3'd0, G,  1'b0, 6'd1,  4'd0);
        add(3,  A1,   3'd0, G,  1'b0, 6'd4,  4'd0);
        add(1,  Q,    3'd0, G,  1'b0, 6'd1,  4'd0);
        add(10, A1,   3'd1, Y,  1'b0, 6'd1,  4'd0);
        add(1,  Q,    3'd3, Y,  1'b0, 6'd1,  4'd0);
        add(1,  DA1,  3'd3, Y,  1'b0, 6'd2,  4'd0);
        add(1,  A3,   3'd4, RD, 1'b1, 6'd1,  4'd0);
        add(80, Q,    3'd4, RD, 1'b1, 6'd63, 4'd0);

        drive(R);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].in, tbl[i].n);
            chk_en = 1'b1;
            nvec++;
            if ({current_state, green, yellow, red, breach, timer, alarm_count} !==
                {tbl[i].st, tbl[i].gyr, tbl[i].br, tbl[i].tm, tbl[i].ac}) begin
                nerr++;
                $display("FAIL row%0d: got st=%0d gyr=%b br=%b tm=%0d ac=%0d, want st=%0d gyr=%b br=%b tm=%0d ac=%0d",
                         i, current_state, {green, yellow, red}, breach, timer, alarm_count,
                         tbl[i].st, tbl[i].gyr, tbl[i].br, tbl[i].tm, tbl[i].ac);
            end
        end

        // Red must stay on through exactly 15 ALARM cycles when activity is masked.
        step(R, 1);
        step(A2, 1);
        for (int i = 1; i <= 15; i++) begin
            step(DA1, 1);
            chk($sformatf("redhold_red%0d", i), int'(red), (i < 15) ? 1 : 0);
        end
        chk("redhold_yellow", int'(yellow), 1);

        // alarm_count saturates at 15 across 16 ALARM entries.
        step(R, 1);
        for (int i = 1; i <= 16; i++) begin
            step(A2, 1);
            chk($sformatf("acount_entry%0d", i), int'(alarm_count), (i < 15) ? i : 15);
            step(Q, 15);
            step(Q, 20);
            chk($sformatf("acount_calm%0d", i), int'(current_state), 0);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
